// File: rtl/stream_core_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// stream_arb_pkg : shared types for the stream core arbiter
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package stream_arb_pkg;

    localparam int N_STRM_MAX = 8;
    localparam int STRM_ID_W  = $clog2(N_STRM_MAX);

    typedef logic [STRM_ID_W-1:0] strm_id_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/stream_core_arbiter_if.sv
// ----------------------------------------------------------------------------
// stream_core_arbiter_if : host request/response vectors plus core in/out
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface stream_core_arbiter_if #(
    parameter int N_STRM = 4,
    parameter int DATA_W = 512
);
    localparam int KEEP_W = DATA_W / 8;

    logic [N_STRM-1:0]        req_tvalid;
    logic [N_STRM-1:0]        req_tready;
    logic [N_STRM*DATA_W-1:0] req_tdata;
    logic [N_STRM*KEEP_W-1:0] req_tkeep;
    logic [N_STRM-1:0]        req_tlast;

    logic                     core_in_tvalid;
    logic                     core_in_tready;
    logic [DATA_W-1:0]        core_in_tdata;
    logic [KEEP_W-1:0]        core_in_tkeep;
    logic                     core_in_tlast;

    logic                     core_out_tvalid;
    logic                     core_out_tready;
    logic [DATA_W-1:0]        core_out_tdata;
    logic [KEEP_W-1:0]        core_out_tkeep;
    logic                     core_out_tlast;

    logic [N_STRM-1:0]        rsp_tvalid;
    logic [N_STRM-1:0]        rsp_tready;
    logic [N_STRM*DATA_W-1:0] rsp_tdata;
    logic [N_STRM*KEEP_W-1:0] rsp_tkeep;
    logic [N_STRM-1:0]        rsp_tlast;

    modport master (
        input  req_tvalid, req_tdata, req_tkeep, req_tlast,
        output req_tready,
        output core_in_tvalid, core_in_tdata, core_in_tkeep, core_in_tlast,
        input  core_in_tready,
        input  core_out_tvalid, core_out_tdata, core_out_tkeep, core_out_tlast,
        output core_out_tready,
        output rsp_tvalid, rsp_tdata, rsp_tkeep, rsp_tlast,
        input  rsp_tready
    );

    modport slave (
        output req_tvalid, req_tdata, req_tkeep, req_tlast,
        input  req_tready,
        input  core_in_tvalid, core_in_tdata, core_in_tkeep, core_in_tlast,
        output core_in_tready,
        output core_out_tvalid, core_out_tdata, core_out_tkeep, core_out_tlast,
        input  core_out_tready,
        input  rsp_tvalid, rsp_tdata, rsp_tkeep, rsp_tlast,
        output rsp_tready
    );

endinterface

`default_nettype wire

// File: rtl/stream_core_arbiter_tag_fifo.sv
// ----------------------------------------------------------------------------
// tag_fifo : small synchronous FIFO holding requester tags of in-flight packets
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tag_fifo #(
    parameter int TAG_DEPTH = 4,
    parameter int ID_W      = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            push,
    input  wire logic            pop,
    input  wire logic [ID_W-1:0] din,
    output logic      [ID_W-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(TAG_DEPTH);

    logic [ID_W-1:0] mem_q [TAG_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    // A pop in the same cycle frees the slot, so a full FIFO may still accept
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(TAG_DEPTH));
    assign empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/stream_core_arbiter.sv
// ----------------------------------------------------------------------------
// stream_core_arbiter : packet round-robin sharing of one stream core, with
// tag-FIFO steering of the order-preserving core output. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stream_core_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_STRM    = 4,
    parameter int DATA_W    = 512,
    parameter int ID_W      = $clog2(N_STRM),
    parameter int TAG_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    stream_core_arbiter_if.master  bus,
    output logic                   busy
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] head;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic            in_hs_last;

    // Farthest candidate first so the nearest valid one after ptr wins
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_STRM-1:0] v,
                                                 input logic [ID_W-1:0]   ptr);
        strm_id_t        cand;
        logic [ID_W-1:0] id;
        rr_pick = ptr;
        for (int k = N_STRM; k >= 1; k--) begin
            cand = strm_id_t'((int'(ptr) + k) % N_STRM);
            id   = ID_W'(cand);
            if (v[id]) begin
                rr_pick = id;
            end
        end
    endfunction

    assign pick       = rr_pick(bus.req_tvalid, rr_ptr_q);
    assign in_hs_last = bus.core_in_tvalid & bus.core_in_tready & bus.core_in_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= ID_W'(N_STRM - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        fifo_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_tvalid && !fifo_full) begin
                    grant_d   = pick;
                    rr_ptr_d  = pick;
                    fifo_push = 1'b1;
                    state_d   = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (in_hs_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.core_in_tvalid = 1'b0;
        bus.core_in_tdata  = bus.req_tdata[int'(grant_q)*DATA_W +: DATA_W];
        bus.core_in_tkeep  = bus.req_tkeep[int'(grant_q)*(DATA_W/8) +: (DATA_W/8)];
        bus.core_in_tlast  = bus.req_tlast[grant_q];
        bus.req_tready     = '0;
        if (state_q == ST_LOCKED) begin
            bus.core_in_tvalid      = bus.req_tvalid[grant_q];
            bus.req_tready[grant_q] = bus.core_in_tready;
        end
    end

    // Egress steering: combinational, only the head requester sees the core
    always_comb begin
        bus.rsp_tvalid      = '0;
        bus.core_out_tready = 1'b0;
        if (!fifo_empty) begin
            bus.rsp_tvalid[head] = bus.core_out_tvalid;
            bus.core_out_tready  = bus.rsp_tready[head];
        end
    end

    assign bus.rsp_tdata = {N_STRM{bus.core_out_tdata}};
    assign bus.rsp_tkeep = {N_STRM{bus.core_out_tkeep}};
    assign bus.rsp_tlast = {N_STRM{bus.core_out_tlast}};

    assign fifo_pop = bus.core_out_tvalid & bus.core_out_tready & bus.core_out_tlast;
    assign busy     = (state_q == ST_LOCKED) | ~fifo_empty;

    tag_fifo #(
        .TAG_DEPTH (TAG_DEPTH),
        .ID_W      (ID_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pick),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_stream_core_arbiter.sv
// ----------------------------------------------------------------------------
// tb_stream_core_arbiter : directed self-checking bench, queue-based core model
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_stream_core_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    stream_core_arbiter_if #(.N_STRM(N), .DATA_W(DW)) bus ();

    stream_core_arbiter #(
        .N_STRM    (N),
        .DATA_W    (DW),
        .TAG_DEPTH (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    // Beat encoding: {tlast, data[31:0]}; response log: {idx[2:0], tlast, data}
    logic [32:0] src_q [N][$];
    logic [32:0] core_q [$];
    int          in_log [$];
    logic [35:0] rsp_log [$];

    logic [N-1:0] src_en, rsp_rdy;
    logic         cin_rdy, cin_rnd, cout_en;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int in_at(input int k);
        return (k < in_log.size()) ? in_log[k] : -1;
    endfunction

    function automatic logic [35:0] rsp_at(input int k);
        return (k < rsp_log.size()) ? rsp_log[k] : '1;
    endfunction

    task automatic drive();
        logic [32:0] b;
        for (int i = 0; i < N; i++) begin
            b = '0;
            if (src_q[i].size() > 0) b = src_q[i][0];
            bus.req_tvalid[i]         = src_en[i] && (src_q[i].size() > 0);
            bus.req_tdata[i*DW +: DW] = b[31:0];
            bus.req_tlast[i]          = b[32];
        end
        bus.req_tkeep      = '1;
        bus.core_in_tready = cin_rnd ? 1'($urandom_range(0, 1)) : cin_rdy;
        b = '0;
        if (core_q.size() > 0) b = core_q[0];
        bus.core_out_tvalid = cout_en && (core_q.size() > 0);
        bus.core_out_tdata  = b[31:0];
        bus.core_out_tlast  = b[32];
        bus.core_out_tkeep  = '1;
        bus.rsp_tready      = rsp_rdy;
    endtask

    task automatic apply();
        drive();
        #1;
    endtask

    // Sample handshakes before the edge, then re-drive after it
    task automatic tick();
        for (int i = 0; i < N; i++) begin
            if (bus.req_tvalid[i] && bus.req_tready[i]) void'(src_q[i].pop_front());
        end
        if (bus.core_out_tvalid && bus.core_out_tready) begin
            void'(core_q.pop_front());
            for (int i = 0; i < N; i++) begin
                if (bus.rsp_tvalid[i] && bus.rsp_tready[i])
                    rsp_log.push_back({3'(i), bus.rsp_tlast[i], bus.rsp_tdata[i*DW +: DW]});
            end
        end
        if (bus.core_in_tvalid && bus.core_in_tready) begin
            core_q.push_back({bus.core_in_tlast, bus.core_in_tdata});
            for (int i = 0; i < N; i++) begin
                if (bus.req_tready[i]) in_log.push_back(i);
            end
        end
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        core_q.delete();
        in_log.delete();
        rsp_log.delete();
        apply();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        apply();
    endtask

    task automatic run_until_rsp(input int n, input int budget, input string tag);
        for (int t = 0; t < budget && rsp_log.size() < n; t++) tick();
        chk(tag, rsp_log.size(), n);
    endtask

    initial begin
        logic [35:0] exp_bp [7];
        int          cnt [N];
        int          bad;

        src_en  = '1;
        rsp_rdy = '1;
        cin_rdy = 1'b1;
        cin_rnd = 1'b0;
        cout_en = 1'b1;
        apply();
        rst = 1'b1;
        apply();

        // Reset state, before any clock edge
        chk("rst_req_tready", bus.req_tready, 0);
        chk("rst_core_in_tvalid", bus.core_in_tvalid, 0);
        chk("rst_core_out_tready", bus.core_out_tready, 0);
        chk("rst_rsp_tvalid", bus.rsp_tvalid, 0);
        chk("rst_busy", busy, 0);

        // Single 3-beat packet from requester 2
        do_reset();
        src_q[2].push_back({1'b0, 32'hA});
        src_q[2].push_back({1'b0, 32'hB});
        src_q[2].push_back({1'b1, 32'hC});
        apply();
        chk("lat_idle_no_offer", bus.core_in_tvalid, 0);
        chk("idle_req_tready", bus.req_tready, 0);
        tick();
        chk("lat_locked_offer", {bus.core_in_tvalid, bus.core_in_tdata}, {1'b1, 32'hA});
        chk("locked_req_tready", bus.req_tready, 4'b0100);
        run_until_rsp(3, 30, "single_timeout");
        chk("single_beat0", rsp_at(0), {3'd2, 1'b0, 32'hA});
        chk("single_beat1", rsp_at(1), {3'd2, 1'b0, 32'hB});
        chk("single_beat2", rsp_at(2), {3'd2, 1'b1, 32'hC});
        repeat (2) tick();
        chk("single_busy_idle", busy, 0);

        // Fairness: all requesters continuously valid with 1-beat packets
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 10; k++) src_q[i].push_back({1'b1, 32'(i*16 + k)});
        apply();
        for (int t = 0; t < 300 && rsp_log.size() < 40; t++) tick();
        chk("fair_done", in_log.size(), 40);
        chk("fair_rsp_done", rsp_log.size(), 40);
        for (int k = 0; k < 8; k++) chk("fair_order", in_at(k), k % 4);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        bad = 0;
        for (int k = 0; k < in_log.size(); k++) if (in_log[k] >= 0 && in_log[k] < N) cnt[in_log[k]]++;
        for (int k = 0; k < rsp_log.size(); k++) if (rsp_log[k][35:33] != {1'b0, rsp_log[k][5:4]}) bad++;
        for (int i = 0; i < N; i++) chk("fair_share", cnt[i], 10);
        chk("fair_routing", bad, 0);

        // Backpressure: random core_in_tready, requesters 1 and 3 interleave
        do_reset();
        cin_rnd = 1'b1;
        src_q[1].push_back({1'b0, 32'h10});
        src_q[1].push_back({1'b0, 32'h14});
        src_q[1].push_back({1'b1, 32'h18});
        src_q[1].push_back({1'b1, 32'h12});
        src_q[3].push_back({1'b0, 32'h11});
        src_q[3].push_back({1'b1, 32'h15});
        src_q[3].push_back({1'b1, 32'h13});
        exp_bp = '{{3'd1, 1'b0, 32'h10}, {3'd1, 1'b0, 32'h14}, {3'd1, 1'b1, 32'h18},
                   {3'd3, 1'b0, 32'h11}, {3'd3, 1'b1, 32'h15},
                   {3'd1, 1'b1, 32'h12}, {3'd3, 1'b1, 32'h13}};
        apply();
        run_until_rsp(7, 400, "bp_timeout");
        cin_rnd = 1'b0;
        for (int k = 0; k < 7; k++) chk("bp_beat", rsp_at(k), exp_bp[k]);
        repeat (4) tick();
        chk("bp_no_extra", rsp_log.size(), 7);

        // Tag FIFO full: core output held, 5th packet must wait for a pop
        do_reset();
        cout_en = 1'b0;
        src_q[0].push_back({1'b1, 32'h60});
        src_q[0].push_back({1'b1, 32'h64});
        src_q[1].push_back({1'b1, 32'h61});
        src_q[2].push_back({1'b1, 32'h62});
        src_q[3].push_back({1'b1, 32'h63});
        apply();
        repeat (20) tick();
        chk("full_granted", in_log.size(), 4);
        chk("full_busy", busy, 1);
        chk("full_req_tready", bus.req_tready, 0);
        chk("full_idle_no_offer", bus.core_in_tvalid, 0);
        cout_en = 1'b1;
        apply();
        cout_en = 1'b0;
        tick();
        chk("full_pop_delivered", rsp_at(0), {3'd0, 1'b1, 32'h60});
        chk("full_no_grant_yet", in_log.size(), 4);
        tick();
        chk("full_grant5_tready", bus.req_tready, 4'b0001);
        tick();
        chk("full_grant5_req", in_at(4), 0);
        cout_en = 1'b1;
        apply();
        run_until_rsp(5, 50, "full_drain_timeout");

        // Response stall on requester 1 blocks requester 0 queued behind it
        do_reset();
        rsp_rdy = 4'b1101;
        src_q[1].push_back({1'b1, 32'h21});
        apply();
        repeat (4) tick();
        src_q[0].push_back({1'b1, 32'h30});
        apply();
        repeat (10) tick();
        chk("stall_core_out_tready", bus.core_out_tready, 0);
        chk("stall_rsp_tvalid", bus.rsp_tvalid, 4'b0010);
        chk("stall_none_delivered", rsp_log.size(), 0);
        rsp_rdy = '1;
        apply();
        run_until_rsp(2, 20, "stall_timeout");
        chk("stall_first", rsp_at(0), {3'd1, 1'b1, 32'h21});
        chk("stall_second", rsp_at(1), {3'd0, 1'b1, 32'h30});

        // Asynchronous reset during beat 2 of a 4-beat packet
        do_reset();
        src_q[2].push_back({1'b0, 32'h40});
        src_q[2].push_back({1'b0, 32'h41});
        src_q[2].push_back({1'b0, 32'h42});
        src_q[2].push_back({1'b1, 32'h43});
        apply();
        repeat (3) tick();
        chk("rstmid_pre_offer", {bus.core_in_tvalid, bus.core_in_tdata}, {1'b1, 32'h42});
        rst = 1'b1;
        #1;
        chk("rstmid_req_tready", bus.req_tready, 0);
        chk("rstmid_core_in_tvalid", bus.core_in_tvalid, 0);
        chk("rstmid_rsp_tvalid", bus.rsp_tvalid, 0);
        chk("rstmid_core_out_tready", bus.core_out_tready, 0);
        chk("rstmid_busy", busy, 0);
        do_reset();
        src_q[0].push_back({1'b1, 32'h50});
        src_q[3].push_back({1'b1, 32'h51});
        apply();
        for (int t = 0; t < 20 && in_log.size() < 2; t++) tick();
        chk("rstmid_first_grant", in_at(0), 0);
        chk("rstmid_second_grant", in_at(1), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
